// File: rtl/norm_48bits_pkg.sv
// Shared constants and operand type for the 48-bit mantissa normalize/round datapath.
package norm_48bits_pkg;
    localparam int MANT_W     = 48;
    localparam int LZ_W       = 6;
    localparam int LZ_ZERO    = 48;
    localparam int NORM_EXP_W = 8;

    typedef struct packed {
        logic [MANT_W-1:0]     mant;
        logic [NORM_EXP_W-1:0] exp;
        logic                  sign;
    } norm_op_t;
endpackage

// File: rtl/lzd_48bits.sv
// Leading-zero detector: p = number of zeros above the highest set bit, v = any bit set.
module lzd_48bits
    import norm_48bits_pkg::*;
(
    input  logic [MANT_W-1:0] in_mant,
    output logic [LZ_W-1:0]   p,
    output logic              v
);
    always_comb begin
        p = '0;
        v = |in_mant;
        // Ascending scan: the highest set bit is the last to write p.
        for (int i = 0; i < MANT_W; i++) begin
            if (in_mant[i]) p = LZ_W'(MANT_W - 1 - i);
        end
    end
endmodule

// File: rtl/norm_48bits.sv
// Two-stage valid/ready mantissa normalizer: S1 = LZD, S2 = barrel shift + exponent adjust.
// Optional performance counters are built when NORM_PERF_CNT_EN is defined.
module norm_48bits
    import norm_48bits_pkg::*;
#(
    parameter int EXP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] in_mant,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic              in_sign,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] out_mant,
    output logic [EXP_W-1:0]  out_exp,
    output logic              out_sign,
    output logic              out_zero,
    output logic              out_uflow
`ifdef NORM_PERF_CNT_EN
    ,
    output logic [15:0]       cnt_norm,
    output logic [15:0]       cnt_uflow
`endif
);
    logic [LZ_W-1:0]   lzd_p;
    logic              lzd_v;
    logic [LZ_W-1:0]   in_lz;

    logic              s1_valid;
    logic [MANT_W-1:0] s1_mant;
    logic [EXP_W-1:0]  s1_exp;
    logic              s1_sign;
    logic [LZ_W-1:0]   s1_lz;

    logic              s2_adv;
    logic              s2_zero;
    logic              s2_uflow;
    logic [LZ_W-1:0]   s2_shift;
    logic [EXP_W:0]    s2_exp_diff;
    logic [MANT_W-1:0] s2_mant;
    logic [EXP_W-1:0]  s2_exp;

    lzd_48bits u_lzd (
        .in_mant (in_mant),
        .p       (lzd_p),
        .v       (lzd_v)
    );

    assign in_lz    = lzd_v ? lzd_p : LZ_W'(LZ_ZERO);
    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mant  <= '0;
            s1_exp   <= '0;
            s1_sign  <= 1'b0;
            s1_lz    <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_mant <= in_mant;
                s1_exp  <= in_exp;
                s1_sign <= in_sign;
                s1_lz   <= in_lz;
            end
        end
    end

    // When the exponent limits the shift it is below lz (<= 47), so it fits in LZ_W bits.
    always_comb begin
        s2_zero     = (s1_lz == LZ_W'(LZ_ZERO));
        s2_uflow    = !s2_zero && (EXP_W'(s1_lz) > s1_exp);
        s2_shift    = s2_uflow ? s1_exp[LZ_W-1:0] : s1_lz;
        s2_exp_diff = {1'b0, s1_exp} - (EXP_W+1)'(s2_shift);
        s2_mant     = s1_mant << s2_shift;
        s2_exp      = s2_exp_diff[EXP_W] ? '0 : s2_exp_diff[EXP_W-1:0];
        if (s2_zero) begin
            s2_mant = '0;
            s2_exp  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_mant  <= '0;
            out_exp   <= '0;
            out_sign  <= 1'b0;
            out_zero  <= 1'b0;
            out_uflow <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_mant  <= s2_mant;
                out_exp   <= s2_exp;
                out_sign  <= s1_sign;
                out_zero  <= s2_zero;
                out_uflow <= s2_uflow;
            end
        end
    end

`ifdef NORM_PERF_CNT_EN
    logic out_xfer;
    assign out_xfer = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_norm  <= '0;
            cnt_uflow <= '0;
        end else begin
            if (out_xfer && !out_zero && cnt_norm != 16'hFFFF)
                cnt_norm <= cnt_norm + 16'd1;
            if (out_xfer && out_uflow && cnt_uflow != 16'hFFFF)
                cnt_uflow <= cnt_uflow + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_norm_48bits.sv
// Directed self-checking bench for norm_48bits (counter tests built with NORM_PERF_CNT_EN).
module tb_norm_48bits;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_mant;
    logic [7:0]  in_exp;
    logic        in_sign;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] out_mant;
    logic [7:0]  out_exp;
    logic        out_sign;
    logic        out_zero;
    logic        out_uflow;
`ifdef NORM_PERF_CNT_EN
    logic [15:0] cnt_norm;
    logic [15:0] cnt_uflow;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    norm_48bits #(.EXP_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mant   (in_mant),
        .in_exp    (in_exp),
        .in_sign   (in_sign),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mant  (out_mant),
        .out_exp   (out_exp),
        .out_sign  (out_sign),
        .out_zero  (out_zero),
        .out_uflow (out_uflow)
`ifdef NORM_PERF_CNT_EN
        ,
        .cnt_norm  (cnt_norm),
        .cnt_uflow (cnt_uflow)
`endif
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_mant = '0; in_exp = '0; in_sign = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_mant = '0; in_exp = '0; in_sign = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, out_mant, out_exp, out_sign, out_zero, out_uflow} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b m=%h e=%0d s=%b z=%b u=%b, want all 0",
                     out_valid, out_mant, out_exp, out_sign, out_zero, out_uflow);
        end
`ifdef NORM_PERF_CNT_EN
        checks++;
        if (cnt_norm !== 16'd0 || cnt_uflow !== 16'd0) begin
            errors++;
            $display("FAIL reset_counters: got %h/%h, want 0/0", cnt_norm, cnt_uflow);
        end
`endif
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
        end
    endtask

    // One isolated operand: checks latency, result fields and that no duplicate follows.
    task automatic test_op(input string nm, input logic [47:0] m, input logic [7:0] e, input logic s,
                           input logic [47:0] em, input logic [7:0] ee, input logic es,
                           input logic ez, input logic eu);
        int lat;
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; in_mant = m; in_exp = e; in_sign = s;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_in_ready: got %b, want 1", nm, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles, want 2", nm, lat);
        end
        checks++;
        if ({out_mant, out_exp, out_sign, out_zero, out_uflow} !== {em, ee, es, ez, eu}) begin
            errors++;
            $display("FAIL %s_result: got m=%h e=%0d s=%b z=%b u=%b, want m=%h e=%0d s=%b z=%b u=%b",
                     nm, out_mant, out_exp, out_sign, out_zero, out_uflow, em, ee, es, ez, eu);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_no_dup: got out_valid=%b, want 0", nm, out_valid);
        end
    endtask

    // Eight operands back-to-back with out_ready dropped for three cycles mid-stream.
    // Operand i = 0x5 << 5i: lz = 45-5i, normalized mant 0xA000_0000_0000, exp = (60+i)-(45-5i).
    task automatic test_back_to_back();
        logic [47:0] em [8];
        logic [7:0]  ee [8];
        logic        es [8];
        logic [47:0] hold_m;
        logic [7:0]  hold_e;
        logic        hold_s, hold_prev;
        int tx, rx, cyc;
        bit saw_block;
        for (int i = 0; i < 8; i++) begin
            em[i] = 48'hA000_0000_0000;
            ee[i] = 8'(15 + 6 * i);
            es[i] = i[0];
        end
        tx = 0; rx = 0; cyc = 0; hold_prev = 1'b0; saw_block = 1'b0;
        hold_m = '0; hold_e = '0; hold_s = 1'b0;
        while (rx < 8 && cyc < 60) begin
            @(negedge clk);
            out_ready = !(cyc >= 4 && cyc <= 6);
            if (tx < 8) begin
                in_valid = 1'b1;
                in_mant  = 48'h5 << (5 * tx);
                in_exp   = 8'(60 + tx);
                in_sign  = tx[0];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (hold_prev) begin
                checks++;
                if (out_valid !== 1'b1 || {out_mant, out_exp, out_sign} !== {hold_m, hold_e, hold_s}) begin
                    errors++;
                    $display("FAIL b2b_stall_stable: got v=%b m=%h e=%0d s=%b, want v=1 m=%h e=%0d s=%b",
                             out_valid, out_mant, out_exp, out_sign, hold_m, hold_e, hold_s);
                end
            end
            if (tx - rx == 2 && !out_ready) begin
                saw_block = 1'b1;
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_full_in_ready: got %b, want 0 at cycle %0d", in_ready, cyc);
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if ({out_mant, out_exp, out_sign, out_zero, out_uflow} !== {em[rx], ee[rx], es[rx], 2'b00}) begin
                    errors++;
                    $display("FAIL b2b_result%0d: got m=%h e=%0d s=%b z=%b u=%b, want m=%h e=%0d s=%b z=0 u=0",
                             rx, out_mant, out_exp, out_sign, out_zero, out_uflow, em[rx], ee[rx], es[rx]);
                end
                rx++;
            end
            hold_prev = (out_valid === 1'b1) && !out_ready;
            hold_m = out_mant; hold_e = out_exp; hold_s = out_sign;
            if (in_valid && in_ready === 1'b1) tx++;
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (rx != 8 || !saw_block) begin
            errors++;
            $display("FAIL b2b_complete: got %0d results (blocked=%0d) in %0d cycles, want 8 (blocked=1)",
                     rx, saw_block, cyc);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL b2b_no_extra: got out_valid=%b, want 0", out_valid);
            end
        end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_mant = 48'h0000_0000_0001; in_exp = 8'd100; in_sign = 1'b0;
        @(negedge clk);
        in_mant = 48'h8000_0000_0000; in_exp = 8'd50; in_sign = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_full: got out_valid=%b in_ready=%b, want 1/0", out_valid, in_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_mant !== 48'h0) begin
            errors++;
            $display("FAIL midrst_clear: got out_valid=%b out_mant=%h, want 0/0", out_valid, out_mant);
        end
        rst = 1'b0; out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midrst_stale: got out_valid=%b, want 0", out_valid);
            end
        end
`ifdef NORM_PERF_CNT_EN
        checks++;
        if (cnt_norm !== 16'd0 || cnt_uflow !== 16'd0) begin
            errors++;
            $display("FAIL midrst_counters: got %h/%h, want 0/0", cnt_norm, cnt_uflow);
        end
`endif
    endtask

`ifdef NORM_PERF_CNT_EN
    task automatic test_counters();
        do_reset();
        test_op("cnt_zero", 48'h0, 8'd5, 1'b0, 48'h0, 8'd0, 1'b0, 1'b1, 1'b0);
        test_op("cnt_uf", 48'h1, 8'd10, 1'b0, 48'h400, 8'd0, 1'b0, 1'b0, 1'b1);
        test_op("cnt_nrm", 48'h1, 8'd100, 1'b0, 48'h8000_0000_0000, 8'd53, 1'b0, 1'b0, 1'b0);
        checks++;
        if (cnt_norm !== 16'd2 || cnt_uflow !== 16'd1) begin
            errors++;
            $display("FAIL cnt_small: got %0d/%0d, want 2/1", cnt_norm, cnt_uflow);
        end
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; in_mant = 48'h1; in_exp = 8'd10; in_sign = 1'b0;
        repeat (66000) @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (cnt_norm !== 16'hFFFF || cnt_uflow !== 16'hFFFF) begin
            errors++;
            $display("FAIL cnt_saturate: got %h/%h, want ffff/ffff", cnt_norm, cnt_uflow);
        end
        do_reset();
        @(negedge clk);
        checks++;
        if (cnt_norm !== 16'd0 || cnt_uflow !== 16'd0) begin
            errors++;
            $display("FAIL cnt_clear: got %h/%h, want 0/0", cnt_norm, cnt_uflow);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_mant = '0; in_exp = '0; in_sign = 1'b0;
        test_reset();
        test_op("already_norm", 48'h8000_0000_0000, 8'd100, 1'b0, 48'h8000_0000_0000, 8'd100, 1'b0, 1'b0, 1'b0);
        test_op("shift47", 48'h0000_0000_0001, 8'd100, 1'b0, 48'h8000_0000_0000, 8'd53, 1'b0, 1'b0, 1'b0);
        test_op("uflow", 48'h0000_0000_0001, 8'd10, 1'b0, 48'h0000_0000_0400, 8'd0, 1'b0, 1'b0, 1'b1);
        test_op("zero", 48'h0, 8'd77, 1'b1, 48'h0, 8'd0, 1'b1, 1'b1, 1'b0);
        test_op("lz_eq_exp", 48'h0000_0000_0001, 8'd47, 1'b0, 48'h8000_0000_0000, 8'd0, 1'b0, 1'b0, 1'b0);
        test_op("uflow_mid", 48'h0000_0000_F000, 8'd20, 1'b1, 48'h000F_0000_0000, 8'd0, 1'b1, 1'b0, 1'b1);
        test_op("shift3", 48'h1234_5678_9ABC, 8'd200, 1'b1, 48'h91A2_B3C4_D5E0, 8'd197, 1'b1, 1'b0, 1'b0);
        test_op("exp0", 48'h4000_0000_0000, 8'd0, 1'b0, 48'h4000_0000_0000, 8'd0, 1'b0, 1'b0, 1'b1);
        test_back_to_back();
        test_reset_midflight();
`ifdef NORM_PERF_CNT_EN
        test_counters();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
